// File: rtl/imem_refill_ctrl.sv
// Instruction-cache line refill controller: reads a run of main-memory words
// and writes them into the I-cache at word offsets 0..N-1, one word per READ/WRITE pair.
module imem_refill_ctrl #(
   parameter int CACHE_AW = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        INEED_change_cache,
   input  logic [31:0] INEED_Base_Addr,
   input  logic [31:0] INEED_High_Addr,
   output logic [31:0] INEED_Addr,
   output logic [31:0] INEED_Din,
   output logic        INEED_WE,
   output logic        INEED_Done,
   output logic        MM_Req,
   output logic [31:0] MM_Addr,
   input  logic        MM_Ack,
   input  logic [31:0] MM_Din,
   output logic        Busy
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] READ  = 2'd1;
   localparam logic [1:0] WRITE = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   logic [1:0]          state_reg;
   logic [31:0]         base_reg;
   logic [31:0]         high_reg;
   logic [31:0]         data_reg;
   logic [CACHE_AW-1:0] cnt_reg;
   logic                wrap_reg;
   logic [31:0]         cur_addr;
   logic                last_word;

   assign cur_addr = base_reg + {{(32-CACHE_AW){1'b0}}, cnt_reg};

   // A range that runs backwards never matches high, so only the counter cap ends it.
   assign last_word = (!wrap_reg && (cur_addr == high_reg)) || (&cnt_reg);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         base_reg  <= '0;
         high_reg  <= '0;
         data_reg  <= '0;
         cnt_reg   <= '0;
         wrap_reg  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (INEED_change_cache) begin
                  base_reg  <= INEED_Base_Addr;
                  high_reg  <= INEED_High_Addr;
                  wrap_reg  <= (INEED_High_Addr < INEED_Base_Addr);
                  cnt_reg   <= '0;
                  state_reg <= READ;
               end
            end
            READ: begin
               if (!INEED_change_cache) begin
                  state_reg <= IDLE;
               end else if (MM_Ack) begin
                  data_reg  <= MM_Din;
                  state_reg <= WRITE;
               end
            end
            WRITE: begin
               if (!INEED_change_cache) begin
                  state_reg <= IDLE;
               end else if (last_word) begin
                  state_reg <= DONE;
               end else begin
                  cnt_reg   <= cnt_reg + CACHE_AW'(1);
                  state_reg <= READ;
               end
            end
            default: begin
               // Stay done while the requester still holds the request.
               if (!INEED_change_cache) begin
                  state_reg <= IDLE;
               end
            end
         endcase
      end
   end

   assign MM_Req     = (state_reg == READ);
   assign MM_Addr    = cur_addr;
   assign INEED_WE   = (state_reg == WRITE);
   assign INEED_Addr = {{(32-CACHE_AW){1'b0}}, cnt_reg};
   assign INEED_Din  = data_reg;
   assign INEED_Done = (state_reg == DONE);
   assign Busy       = (state_reg != IDLE);

endmodule
